// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Report channel between the deadlock report scheduler and the testbench logger.
// The master side presents reports; the slave side accepts them with rpt_ready.
interface aesl_deadlock_report_ctrl_if #(
  parameter int IDX_W  = 2,
  parameter int INFO_W = 1,
  parameter int CNT_W  = 16
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [IDX_W-1:0]  rpt_idx;
  logic [INFO_W-1:0] rpt_info;
  logic [CNT_W-1:0]  rpt_cycles;

  modport master (
    output rpt_valid, rpt_idx, rpt_info, rpt_cycles,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_idx, rpt_info, rpt_cycles,
    output rpt_ready
  );
endinterface

// File: rtl/aesl_deadlock_report_ctrl.sv
// Deadlock report scheduler: qualifies each monitor's block flag against a sustained-cycle
// threshold, latches a sticky deadlock flag and serialises one report per blocking episode.
module aesl_deadlock_report_ctrl #(
  parameter int NUM_MON   = 4,
  parameter int IDX_W     = 2,
  parameter int INFO_W    = 1,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clr,
  input  logic [NUM_MON-1:0]          mon_block,
  input  logic [NUM_MON*INFO_W-1:0]   mon_info,
  aesl_deadlock_report_ctrl_if.master rpt,
  output logic                        deadlock,
  output logic                        busy
);
  typedef enum logic {IDLE = 1'b0, REPORT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] THR_M1   = CNT_W'(THRESHOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MON - 1);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt      [NUM_MON];
  logic [INFO_W-1:0]  info_arr [NUM_MON];
  logic [NUM_MON-1:0] armed, pending, qual;
  logic [IDX_W-1:0]   rr_ptr, sel_idx, cand;
  logic               sel_found, launch, handshake;

  // A monitor qualifies on the single edge its count crosses into the threshold.
  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      info_arr[i] = mon_info[i*INFO_W +: INFO_W];
      qual[i]     = enable & mon_block[i] & armed[i] & (cnt[i] == THR_M1);
    end
  end

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_MON; k++) begin
      cand = (int'(rr_ptr) + k >= NUM_MON) ? IDX_W'(int'(rr_ptr) + k - NUM_MON)
                                           : IDX_W'(int'(rr_ptr) + k);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // NOTE: every output of a combinational block is defaulted first, so no path leaves a latch.
  always_comb begin
    state_d   = state;
    launch    = 1'b0;
    handshake = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (sel_found) begin
          launch  = 1'b1;
          state_d = REPORT;
        end
        REPORT: if (rpt.rpt_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: the counter array is control state, not data storage, so it is reset like any flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
      armed    <= '1;
      pending  <= '0;
      deadlock <= 1'b0;
      rr_ptr   <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
      armed    <= '1;
      pending  <= '0;
      deadlock <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (handshake) begin
        pending[rpt.rpt_idx] <= 1'b0;
        rr_ptr               <= (rpt.rpt_idx == LAST_IDX) ? '0 : rpt.rpt_idx + 1'b1;
      end
      // A same-edge qualification is assigned after the handshake clear and wins.
      for (int i = 0; i < NUM_MON; i++) begin
        if (enable && mon_block[i]) begin
          if (cnt[i] != THR) cnt[i] <= cnt[i] + 1'b1;
          if (qual[i]) begin
            pending[i] <= 1'b1;
            armed[i]   <= 1'b0;
          end
        end else begin
          cnt[i]   <= '0;
          armed[i] <= 1'b1;
        end
      end
      if (|qual) deadlock <= 1'b1;
    end
  end

  // Report fields are snapshots taken at launch and held until the next launch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt.rpt_idx    <= '0;
      rpt.rpt_info   <= '0;
      rpt.rpt_cycles <= '0;
    end else if (launch) begin
      rpt.rpt_idx    <= sel_idx;
      rpt.rpt_info   <= info_arr[sel_idx];
      rpt.rpt_cycles <= cnt[sel_idx];
    end
  end

  assign rpt.rpt_valid = (state == REPORT);
  assign busy          = (state == REPORT);
endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Self-checking bench for aesl_deadlock_report_ctrl: directed scenarios plus a randomized
// run compared each cycle against a run-length based reference model.
module tb_aesl_deadlock_report_ctrl;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int IW = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          clr;
  logic [N-1:0]  mon_block;
  logic [N*IW-1:0] mon_info;
  logic          deadlock;
  logic          busy;

  int errors = 0;
  int checks = 0;

  aesl_deadlock_report_ctrl_if #(.IDX_W(2), .INFO_W(IW), .CNT_W(CW)) rpt_if ();

  aesl_deadlock_report_ctrl #(
    .NUM_MON(N), .IDX_W(2), .INFO_W(IW), .CNT_W(CW), .THRESHOLD(T)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clr       (clr),
    .mon_block (mon_block),
    .mon_info  (mon_info),
    .rpt       (rpt_if.master),
    .deadlock  (deadlock),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Reference model: run[i] is the length of the current enabled blocking run;
  // a monitor qualifies exactly when its run length reaches T.
  int          m_run  [N];
  bit          m_pend [N];
  bit          m_dead;
  int          m_ptr;
  bit          m_rep;
  int          m_idx;
  logic [IW-1:0] m_info;
  int          m_cyc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_pend[i] = 0;
    end
    m_dead = 0; m_ptr = 0; m_rep = 0; m_idx = 0; m_info = '0; m_cyc = 0;
  endtask

  task automatic model_step();
    bit np [N];
    int j;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_run[i]  = 0;
        m_pend[i] = 0;
      end
      m_dead = 0; m_ptr = 0; m_rep = 0;
      return;
    end
    for (int i = 0; i < N; i++) np[i] = m_pend[i];
    if (m_rep) begin
      if (rpt_if.rpt_ready) begin
        np[m_idx] = 0;
        m_ptr     = (m_idx + 1) % N;
        m_rep     = 0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        j = (m_ptr + s) % N;
        if (m_pend[j]) begin
          m_idx  = j;
          m_info = mon_info[j*IW +: IW];
          m_cyc  = (m_run[j] < T) ? m_run[j] : T;
          m_rep  = 1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (enable && mon_block[i]) begin
        m_run[i]++;
        if (m_run[i] == T) begin
          np[i]  = 1;
          m_dead = 1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) m_pend[i] = np[i];
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; clr = 1'b0; mon_block = '0; mon_info = '0; rpt_if.rpt_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; clr = 1'b0; mon_block = '0; mon_info = '0; rpt_if.rpt_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rpt_if.rpt_valid); end
    checks++; if (rpt_if.rpt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", rpt_if.rpt_idx); end
    checks++; if (rpt_if.rpt_info !== 3'd0) begin errors++; $display("FAIL reset_info: got %0d want 0", rpt_if.rpt_info); end
    checks++; if (rpt_if.rpt_cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", rpt_if.rpt_cycles); end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock: got %b want 0", deadlock); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_single_threshold();
    int extra;
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b1; mon_block = 4'b0010;
    repeat (T - 1) tick();
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL single_early_deadlock: got %b want 0", deadlock); end
    tick();
    checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL single_deadlock: got %b want 1", deadlock); end
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", rpt_if.rpt_valid); end
    tick();
    checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rpt_if.rpt_valid); end
    checks++; if (rpt_if.rpt_idx !== 2'd1) begin errors++; $display("FAIL single_idx: got %0d want 1", rpt_if.rpt_idx); end
    checks++; if (rpt_if.rpt_cycles !== 16'(T)) begin errors++; $display("FAIL single_cycles: got %0d want %0d", rpt_if.rpt_cycles, T); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    extra = 0;
    repeat (12) begin
      tick();
      if (rpt_if.rpt_valid === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL single_no_repeat: got %0d reports want 0", extra); end
  endtask

  task automatic test_short_pulse();
    int seen;
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b1;
    seen = 0;
    mon_block = 4'b0001;
    repeat (T - 1) begin tick(); if (rpt_if.rpt_valid === 1'b1) seen++; end
    mon_block = 4'b0000;
    tick(); if (rpt_if.rpt_valid === 1'b1) seen++;
    mon_block = 4'b0001;
    repeat (T - 1) begin tick(); if (rpt_if.rpt_valid === 1'b1) seen++; end
    mon_block = 4'b0000;
    repeat (3) begin tick(); if (rpt_if.rpt_valid === 1'b1) seen++; end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL short_deadlock: got %b want 0", deadlock); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL short_reports: got %0d want 0", seen); end
  endtask

  task automatic test_round_robin();
    bit exp_v;
    logic [1:0] exp_i;
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b1; mon_block = 4'b1101;
    repeat (T) tick();
    checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL rr_deadlock: got %b want 1", deadlock); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = (k == 1) || (k == 3) || (k == 5);
      exp_i = (k == 1) ? 2'd0 : (k == 3) ? 2'd2 : 2'd3;
      checks++; if (rpt_if.rpt_valid !== exp_v) begin errors++; $display("FAIL rr_valid_t%0d: got %b want %b", k, rpt_if.rpt_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rpt_if.rpt_idx !== exp_i) begin errors++; $display("FAIL rr_idx_t%0d: got %0d want %0d", k, rpt_if.rpt_idx, exp_i); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b0; mon_block = 4'b0100;
    mon_info = {3'b000, 3'b101, 3'b000, 3'b000};
    repeat (T) tick();
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", k, rpt_if.rpt_valid); end
      checks++; if (rpt_if.rpt_idx !== 2'd2) begin errors++; $display("FAIL bp_idx_c%0d: got %0d want 2", k, rpt_if.rpt_idx); end
      checks++; if (rpt_if.rpt_info !== 3'b101) begin errors++; $display("FAIL bp_info_c%0d: got %0d want 5", k, rpt_if.rpt_info); end
      checks++; if (rpt_if.rpt_cycles !== 16'(T)) begin errors++; $display("FAIL bp_cycles_c%0d: got %0d want %0d", k, rpt_if.rpt_cycles, T); end
      mon_info = 12'($urandom);
      tick();
    end
    rpt_if.rpt_ready = 1'b1;
    checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_before_ready: got %b want 1", rpt_if.rpt_valid); end
    tick();
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_complete: got %b want 0", rpt_if.rpt_valid); end
  endtask

  task automatic test_clear_mid_report();
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b0; mon_block = 4'b1000;
    repeat (T + 1) tick();
    checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", rpt_if.rpt_valid); end
    clr = 1'b1; mon_block = 4'b0000;
    tick();
    clr = 1'b0;
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", rpt_if.rpt_valid); end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL clr_deadlock: got %b want 0", deadlock); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    mon_block = 4'b1000; rpt_if.rpt_ready = 1'b1;
    repeat (T - 1) tick();
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL clr_requal_early: got %b want 0", deadlock); end
    tick();
    checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL clr_requal: got %b want 1", deadlock); end
    tick();
    checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL clr_rereport_valid: got %b want 1", rpt_if.rpt_valid); end
    checks++; if (rpt_if.rpt_idx !== 2'd3) begin errors++; $display("FAIL clr_rereport_idx: got %0d want 3", rpt_if.rpt_idx); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; rpt_if.rpt_ready = 1'b0; mon_block = 4'b0010;
    repeat (T + 1) tick();
    checks++; if (rpt_if.rpt_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", rpt_if.rpt_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", rpt_if.rpt_valid); end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL areset_deadlock: got %b want 0", deadlock); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(39) != 0);
      clr    = ($urandom_range(299) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(11) == 0) mon_block[i] = ~mon_block[i];
      mon_info = 12'($urandom);
      rpt_if.rpt_ready = ($urandom_range(9) < 7);
      tick();
      checks++; if (rpt_if.rpt_valid !== m_rep) begin errors++; $display("FAIL rnd_valid_c%0d: got %b want %b", c, rpt_if.rpt_valid, m_rep); end
      checks++; if (busy !== m_rep) begin errors++; $display("FAIL rnd_busy_c%0d: got %b want %b", c, busy, m_rep); end
      checks++; if (deadlock !== m_dead) begin errors++; $display("FAIL rnd_deadlock_c%0d: got %b want %b", c, deadlock, m_dead); end
      checks++; if (rpt_if.rpt_idx !== 2'(m_idx)) begin errors++; $display("FAIL rnd_idx_c%0d: got %0d want %0d", c, rpt_if.rpt_idx, m_idx); end
      checks++; if (rpt_if.rpt_info !== m_info) begin errors++; $display("FAIL rnd_info_c%0d: got %0d want %0d", c, rpt_if.rpt_info, m_info); end
      checks++; if (rpt_if.rpt_cycles !== 16'(m_cyc)) begin errors++; $display("FAIL rnd_cycles_c%0d: got %0d want %0d", c, rpt_if.rpt_cycles, m_cyc); end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_threshold();
    test_short_pulse();
    test_round_robin();
    test_backpressure();
    test_clear_mid_report();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
